// File: rtl/aud_pkg.sv
// Shared audio definitions: recorder state encoding and SRAM/sample widths,
// common to the recorder and the playback DSP block.
package aud_pkg;

   localparam int unsigned ADDR_W   = 20;
   localparam int unsigned SAMPLE_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WAIT  = 3'd1,
      ST_CAPT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_PAUSE = 3'd4,
      ST_FULL  = 3'd5
   } rec_state_e;

endpackage

// File: rtl/i2s_rx.sv
// I2S receive front end: synchronizes the codec lines, finds BCLK rises and
// LRC edges, skips the one-bit delay and shifts in one 16-bit MSB-first word.
module i2s_rx
   import aud_pkg::*;
#(
   parameter int unsigned CHANNEL = 0
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_bclk,
   input  logic                i_lrc,
   input  logic                i_adc_data,
   input  logic                i_capt,
   output logic                o_frame_start,
   output logic [SAMPLE_W-1:0] o_sample,
   output logic                o_valid
);

   localparam logic       CH_LRC   = (CHANNEL != 0);
   localparam logic [4:0] LAST_BIT = 5'(SAMPLE_W);

   // [1] is the synchronized value, [2] its one-cycle history for edge detection
   logic [2:0]          bclk_sr;
   logic [2:0]          lrc_sr;
   logic [1:0]          data_sr;
   logic [SAMPLE_W-1:0] shreg;
   logic [4:0]          bit_cnt;
   logic                bclk_rise;

   assign bclk_rise     = bclk_sr[1] & ~bclk_sr[2];
   assign o_frame_start = (lrc_sr[1] ^ lrc_sr[2]) && (lrc_sr[1] == CH_LRC);
   assign o_sample      = shreg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bclk_sr <= '0;
         lrc_sr  <= '0;
         data_sr <= '0;
      end else begin
         bclk_sr <= {bclk_sr[1:0], i_bclk};
         lrc_sr  <= {lrc_sr[1:0], i_lrc};
         data_sr <= {data_sr[0], i_adc_data};
      end
   end

   // bit_cnt: 0 = delay bit pending, 1..16 = data bits, 17 = slot done
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
         o_valid <= 1'b0;
      end else begin
         o_valid <= 1'b0;
         if (o_frame_start) begin
            bit_cnt <= '0;
         end else if (i_capt && bclk_rise) begin
            if (bit_cnt == 5'd0) begin
               bit_cnt <= 5'd1;
            end else if (bit_cnt <= LAST_BIT) begin
               shreg   <= {shreg[SAMPLE_W-2:0], data_sr[1]};
               bit_cnt <= bit_cnt + 5'd1;
               if (bit_cnt == LAST_BIT) o_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/aud_recorder.sv
// Audio recorder: captures one I2S channel and streams signed 16-bit samples
// into SRAM with start/pause/stop control and a full-memory stop.
module aud_recorder
   import aud_pkg::*;
#(
   parameter logic [19:0] ADDR_MAX = 20'hFFFFF,
   parameter int unsigned CHANNEL  = 0
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_pause,
   input  logic        i_stop,
   input  logic        i_bclk,
   input  logic        i_lrc,
   input  logic        i_adc_data,
   output logic [19:0] o_sram_addr,
   output logic [15:0] o_sram_data,
   output logic        o_sram_we,
   output logic [19:0] o_last_addr,
   output logic        o_full,
   output logic [2:0]  o_state
);

   rec_state_e          state, state_nxt;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   last_q;
   logic [SAMPLE_W-1:0] data_q;
   logic                frame_start;
   logic                valid;
   logic [SAMPLE_W-1:0] sample;

   i2s_rx #(
      .CHANNEL(CHANNEL)
   ) u_rx (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_bclk       (i_bclk),
      .i_lrc        (i_lrc),
      .i_adc_data   (i_adc_data),
      .i_capt       (state == ST_CAPT),
      .o_frame_start(frame_start),
      .o_sample     (sample),
      .o_valid      (valid)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (i_stop) begin
         state_nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE:  if (i_start) state_nxt = ST_WAIT;
            ST_WAIT: begin
               if (i_pause)          state_nxt = ST_PAUSE;
               else if (frame_start) state_nxt = ST_CAPT;
            end
            ST_CAPT: begin
               if (i_pause)    state_nxt = ST_PAUSE;
               else if (valid) state_nxt = ST_WRITE;
            end
            // a pending pause only takes effect once the strobe has been issued
            ST_WRITE: begin
               if (addr_q == ADDR_MAX) state_nxt = ST_FULL;
               else if (i_pause)       state_nxt = ST_PAUSE;
               else                    state_nxt = ST_WAIT;
            end
            ST_PAUSE: if (!i_pause && i_start) state_nxt = ST_WAIT;
            ST_FULL:  state_nxt = ST_FULL;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      o_sram_we   = (state == ST_WRITE);
      o_full      = (state == ST_FULL);
      o_state     = state;
      o_sram_addr = addr_q;
      o_last_addr = last_q;
      o_sram_data = data_q;
   end

   // a strobe in flight completes even under stop, so last_q still records it
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q <= '0;
         last_q <= '0;
         data_q <= '0;
      end else begin
         if (state == ST_CAPT && valid) data_q <= sample;
         if (state == ST_WRITE)         last_q <= addr_q;
         if (i_stop || state == ST_IDLE)
            addr_q <= '0;
         else if (state == ST_WRITE && addr_q != ADDR_MAX)
            addr_q <= addr_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_aud_recorder.sv
// Bench for aud_recorder: three instances (left, right, small memory) share
// one I2S stream; a write scoreboard plus table rows and corner sequences.
module tb_aud_recorder;

   logic clk = 1'b0, rst_n = 1'b0, bclk = 1'b0, lrc = 1'b1, adc = 1'b0;
   logic start0 = 0, pause0 = 0, stop0 = 0;
   logic start1 = 0, pause1 = 0, stop1 = 0;
   logic start2 = 0, pause2 = 0, stop2 = 0;
   logic [19:0] addr0, addr1, addr2, last0, last1, last2;
   logic [15:0] data0, data1, data2;
   logic        we0, we1, we2, full0, full1, full2;
   logic [2:0]  st0, st1, st2;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [19:0] addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      logic [15:0] left;
      logic [15:0] right;
      logic [19:0] exp_last0;
   } vec_t;

   wr_t  q0[$], q1[$], q2[$];
   vec_t vecs[5];

   always #5 clk = ~clk;

   aud_recorder dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_pause(pause0), .i_stop(stop0),
      .i_bclk(bclk), .i_lrc(lrc), .i_adc_data(adc),
      .o_sram_addr(addr0), .o_sram_data(data0), .o_sram_we(we0),
      .o_last_addr(last0), .o_full(full0), .o_state(st0));

   aud_recorder #(.CHANNEL(1)) dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_pause(pause1), .i_stop(stop1),
      .i_bclk(bclk), .i_lrc(lrc), .i_adc_data(adc),
      .o_sram_addr(addr1), .o_sram_data(data1), .o_sram_we(we1),
      .o_last_addr(last1), .o_full(full1), .o_state(st1));

   aud_recorder #(.ADDR_MAX(20'd3)) dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_pause(pause2), .i_stop(stop2),
      .i_bclk(bclk), .i_lrc(lrc), .i_adc_data(adc),
      .o_sram_addr(addr2), .o_sram_data(data2), .o_sram_we(we2),
      .o_last_addr(last2), .o_full(full2), .o_state(st2));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (we0 === 1'b1) begin
            wr_t e;
            checks++;
            if (q0.size() == 0) begin
               errors++;
               $display("FAIL wr0_unexpected: got addr=%0h data=%0h required no write", addr0, data0);
            end else begin
               e = q0.pop_front();
               if (e.addr !== addr0 || e.data !== data0) begin
                  errors++;
                  $display("FAIL wr0: got addr=%0h data=%0h required addr=%0h data=%0h",
                           addr0, data0, e.addr, e.data);
               end
            end
         end
         if (we1 === 1'b1) begin
            wr_t e;
            checks++;
            if (q1.size() == 0) begin
               errors++;
               $display("FAIL wr1_unexpected: got addr=%0h data=%0h required no write", addr1, data1);
            end else begin
               e = q1.pop_front();
               if (e.addr !== addr1 || e.data !== data1) begin
                  errors++;
                  $display("FAIL wr1: got addr=%0h data=%0h required addr=%0h data=%0h",
                           addr1, data1, e.addr, e.data);
               end
            end
         end
         if (we2 === 1'b1) begin
            wr_t e;
            checks++;
            if (q2.size() == 0) begin
               errors++;
               $display("FAIL wr2_unexpected: got addr=%0h data=%0h required no write", addr2, data2);
            end else begin
               e = q2.pop_front();
               if (e.addr !== addr2 || e.data !== data2) begin
                  errors++;
                  $display("FAIL wr2: got addr=%0h data=%0h required addr=%0h data=%0h",
                           addr2, data2, e.addr, e.data);
               end
            end
         end
      end
   endtask

   // One I2S slot of 18 BCLKs (period 80 ns = 8 clk): delay bit, 16 data bits,
   // one extra bit. act 1 raises pause0, act 2 raises stop0+pause0 at bit act_k.
   task automatic drive_slot(input logic lv, input logic [15:0] w, input int act_k, input int act);
      for (int k = 0; k < 18; k++) begin
         bclk = 1'b0;
         if (k == 0) lrc = lv;
         if (k >= 1 && k <= 16) adc = w[16-k];
         else                   adc = 1'b1;
         if (k == act_k) begin
            if (act == 1) pause0 = 1'b1;
            else if (act == 2) begin
               pause0 = 1'b1;
               stop0  = 1'b1;
            end
         end
         #40;
         bclk = 1'b1;
         #40;
      end
   endtask

   task automatic drive_frame(input logic [15:0] l, input logic [15:0] r);
      drive_slot(1'b0, l, -1, 0);
      drive_slot(1'b1, r, -1, 0);
   endtask

   task automatic push0(input logic [19:0] a, input logic [15:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      q0.push_back(w);
   endtask

   initial begin
      wr_t w;
      vecs[0] = '{16'h8001, 16'h1234, 20'd0};
      vecs[1] = '{16'h7FFE, 16'h0F0F, 20'd1};
      vecs[2] = '{16'h0000, 16'hFFFF, 20'd2};
      vecs[3] = '{16'h5A5A, 16'hA5A5, 20'd3};
      vecs[4] = '{16'hC3C3, 16'h3C3C, 20'd4};

      fork
         monitor();
      join_none

      #27;
      chk("rst_addr", addr0, 0);
      chk("rst_we", we0, 0);
      chk("rst_last", last0, 0);
      chk("rst_data", data0, 0);
      chk("rst_full", full0, 0);
      chk("rst_state", st0, 0);
      chk("rst_state2", st2, 0);
      rst_n = 1'b1;
      #100;
      start0 = 1; start1 = 1; start2 = 1;
      #20;
      start0 = 0; start1 = 0; start2 = 0;
      #10;
      chk("start_wait", st0, 1);

      for (int i = 0; i < 5; i++) begin
         push0(20'(i), vecs[i].left);
         w.addr = 20'(i);
         w.data = vecs[i].right;
         q1.push_back(w);
         if (i < 4) begin
            w.data = vecs[i].left;
            q2.push_back(w);
         end
         drive_frame(vecs[i].left, vecs[i].right);
         #200;
         chk("row_last0", last0, vecs[i].exp_last0);
      end
      chk("ch1_last", last1, 4);
      chk("ch0_state", st0, 1);
      chk("full_state", st2, 5);
      chk("full_flag", full2, 1);
      chk("full_addr", addr2, 3);
      chk("full_last", last2, 3);
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);

      stop1 = 1; stop2 = 1;
      #20;
      chk("full_stop_state", st2, 0);
      chk("full_stop_addr", addr2, 0);
      chk("full_stop_last", last2, 3);
      chk("full_stop_flag", full2, 0);
      chk("ch1_stop_addr", addr1, 0);

      // pause after 8 bits of a left sample; the partial word must never be written
      drive_slot(1'b0, 16'h00FF, 9, 1);
      drive_slot(1'b1, 16'h0000, -1, 0);
      chk("pause_state", st0, 4);
      chk("pause_addr", addr0, 5);
      chk("pause_last", last0, 4);
      pause0 = 0; start0 = 1;
      #20;
      start0 = 0;
      #10;
      chk("resume_state", st0, 1);
      push0(20'd5, 16'hABCD);
      drive_frame(16'hABCD, 16'h0000);
      #200;
      chk("resume_last", last0, 5);
      chk("resume_addr", addr0, 6);

      // stop and pause together mid-capture
      drive_slot(1'b0, 16'h1357, 5, 2);
      #20;
      chk("stoppause_state", st0, 0);
      chk("stoppause_addr", addr0, 0);
      chk("stoppause_last", last0, 5);
      chk("stoppause_we", we0, 0);
      stop0 = 0; pause0 = 0;
      drive_slot(1'b1, 16'h0000, -1, 0);

      start0 = 1;
      #20;
      start0 = 0;
      #10;
      chk("restart_state", st0, 1);
      fork
         drive_frame(16'h1111, 16'h0000);
         begin : rst_branch
            logic hit;
            hit = 1'b0;
            for (int c = 0; c < 400; c++) begin
               @(posedge clk);
               #1;
               if (we0 === 1'b1) begin
                  hit = 1'b1;
                  break;
               end
            end
            chk("rst_wr_seen", hit, 1);
            rst_n = 1'b0;
            #1;
            chk("rstw_we", we0, 0);
            chk("rstw_addr", addr0, 0);
            chk("rstw_last", last0, 0);
            chk("rstw_data", data0, 0);
            chk("rstw_state", st0, 0);
            chk("rstw_full", full0, 0);
         end
      join
      rst_n = 1'b1;
      #100;
      start0 = 1;
      #20;
      start0 = 0;
      push0(20'd0, 16'h2468);
      drive_frame(16'h2468, 16'h0000);
      #200;
      chk("post_rst_addr", addr0, 1);
      chk("post_rst_last", last0, 0);
      chk("q0_final", q0.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
